// File: rtl/fetch_unit.sv
// Instruction-fetch front end: tracks the byte PC, issues 1-cycle-latency reads,
// and buffers up to two {pc, instruction} pairs toward decode.
module fetch_unit #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter int                MEM_WORDS = 32
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] endereco,
    output logic            req,
    input  logic [XLEN-1:0] instrucao,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            fim
);

    typedef enum logic [1:0] {START, FETCH, HALT} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_req, inflight_pc;
    logic            inflight;
    logic [1:0]      count;
    entry_t          head, tail, resp;
    logic            in_range, take, pop, push, flush;
    logic [2:0]      credit;

    assign endereco    = pc_req >> 2;
    assign in_range    = endereco < XLEN'(MEM_WORDS);
    assign instr_valid = (count != 2'd0);
    assign take        = instr_valid & instr_ready;
    assign flush       = redirect & (state != START);
    // a redirect cycle neither consumes the head nor accepts the stale response
    assign pop         = take & ~redirect;
    assign push        = inflight & ~redirect;
    assign resp        = '{pc: inflight_pc, instr: instrucao};

    // entries held plus the one on its way must leave room for a new response
    assign credit      = {1'b0, count} + {2'b00, inflight} - {2'b00, take};
    assign req         = (state == FETCH) & ~redirect & in_range & (credit < 3'd2);

    assign instr_out   = head.instr;
    assign instr_pc    = head.pc;
    assign fim         = (state == HALT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= START;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            START:   state_nxt = FETCH;
            FETCH: begin
                if (redirect)                    state_nxt = FETCH;
                else if (!in_range && !inflight) state_nxt = HALT;
            end
            HALT:    if (redirect) state_nxt = FETCH;
            default: state_nxt = START;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_req      <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
        end else if (flush) begin
            pc_req      <= redirect_pc & ~XLEN'(3);
            inflight    <= 1'b0;
        end else begin
            inflight    <= req;
            if (req) begin
                inflight_pc <= pc_req;
                pc_req      <= pc_req + XLEN'(4);
            end
        end
    end

    // head register is the output; it keeps its last contents when the FIFO drains
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= resp;
                    else               tail <= resp;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= resp;
                    end else begin
                        head <= resp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand sequences
// for the same-cycle redirect/pop case and asynchronous reset.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] endereco;
    logic        req;
    logic [31:0] instrucao = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;
    logic        fim;

    int n_run  = 0;
    int n_fail = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .MEM_WORDS(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .endereco    (endereco),
        .req         (req),
        .instrucao   (instrucao),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .fim         (fim)
    );

    always #5 clock = ~clock;

    // instruction memory: words 0..3 from the program, the rest tagged with their index
    logic [31:0] mem [0:31];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0640_0193;
        mem[1] = 32'h0C80_0213;
        mem[2] = 32'h12C0_0293;
        mem[3] = 32'h1900_0313;
    end

    always @(posedge clock) if (req) instrucao <= mem[endereco[4:0]];

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_out;
        logic        e_fim;
    } vec_t;

    vec_t tbl [0:29];

    function automatic vec_t mk(logic rdy, logic rd, logic [31:0] rpc, logic e_req,
                                logic [31:0] e_addr, logic e_vld, logic [31:0] e_pc,
                                logic [31:0] e_out, logic e_fim);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
        v.e_vld = e_vld; v.e_pc = e_pc; v.e_out = e_out; v.e_fim = e_fim;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step(logic rdy, logic rd, logic [31:0] rpc);
        @(negedge clock);
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic check_outs(string tag, logic e_req, logic [31:0] e_addr, logic e_vld,
                              logic [31:0] e_pc, logic [31:0] e_out, logic e_fim);
        chk({tag, ".req"},      {31'b0, req},         {31'b0, e_req});
        chk({tag, ".endereco"}, endereco,             e_addr);
        chk({tag, ".valid"},    {31'b0, instr_valid}, {31'b0, e_vld});
        chk({tag, ".pc"},       instr_pc,             e_pc);
        chk({tag, ".out"},      instr_out,            e_out);
        chk({tag, ".fim"},      {31'b0, fim},         {31'b0, e_fim});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // stream start, stall, redirect to 0x3E, run to end of memory, halt, resume at 0x13
        tbl[0]  = mk(1, 0, 0,     1,  0, 0, 32'h00, 32'h0,         0);
        tbl[1]  = mk(1, 0, 0,     1,  1, 0, 32'h00, 32'h0,         0);
        tbl[2]  = mk(1, 0, 0,     1,  2, 1, 32'h00, 32'h0640_0193, 0);
        tbl[3]  = mk(1, 0, 0,     1,  3, 1, 32'h04, 32'h0C80_0213, 0);
        tbl[4]  = mk(0, 0, 0,     0,  4, 1, 32'h08, 32'h12C0_0293, 0);
        tbl[5]  = mk(0, 0, 0,     0,  4, 1, 32'h08, 32'h12C0_0293, 0);
        tbl[6]  = mk(0, 0, 0,     0,  4, 1, 32'h08, 32'h12C0_0293, 0);
        tbl[7]  = mk(0, 0, 0,     0,  4, 1, 32'h08, 32'h12C0_0293, 0);
        tbl[8]  = mk(0, 0, 0,     0,  4, 1, 32'h08, 32'h12C0_0293, 0);
        tbl[9]  = mk(1, 0, 0,     1,  4, 1, 32'h08, 32'h12C0_0293, 0);
        tbl[10] = mk(1, 0, 0,     1,  5, 1, 32'h0C, 32'h1900_0313, 0);
        tbl[11] = mk(1, 0, 0,     1,  6, 1, 32'h10, 32'hA000_0004, 0);
        tbl[12] = mk(1, 1, 32'h3E,0,  7, 1, 32'h14, 32'hA000_0005, 0);
        tbl[13] = mk(1, 0, 0,     1, 15, 0, 32'h14, 32'hA000_0005, 0);
        tbl[14] = mk(1, 0, 0,     1, 16, 0, 32'h14, 32'hA000_0005, 0);
        tbl[15] = mk(1, 0, 0,     1, 17, 1, 32'h3C, 32'hA000_000F, 0);
        tbl[16] = mk(1, 0, 0,     1, 18, 1, 32'h40, 32'hA000_0010, 0);
        tbl[17] = mk(1, 1, 32'h70,0, 19, 1, 32'h44, 32'hA000_0011, 0);
        tbl[18] = mk(1, 0, 0,     1, 28, 0, 32'h44, 32'hA000_0011, 0);
        tbl[19] = mk(1, 0, 0,     1, 29, 0, 32'h44, 32'hA000_0011, 0);
        tbl[20] = mk(1, 0, 0,     1, 30, 1, 32'h70, 32'hA000_001C, 0);
        tbl[21] = mk(1, 0, 0,     1, 31, 1, 32'h74, 32'hA000_001D, 0);
        tbl[22] = mk(1, 0, 0,     0, 32, 1, 32'h78, 32'hA000_001E, 0);
        tbl[23] = mk(1, 0, 0,     0, 32, 1, 32'h7C, 32'hA000_001F, 0);
        tbl[24] = mk(1, 0, 0,     0, 32, 0, 32'h7C, 32'hA000_001F, 1);
        tbl[25] = mk(1, 0, 0,     0, 32, 0, 32'h7C, 32'hA000_001F, 1);
        tbl[26] = mk(1, 1, 32'h13,0, 32, 0, 32'h7C, 32'hA000_001F, 1);
        tbl[27] = mk(1, 0, 0,     1,  4, 0, 32'h7C, 32'hA000_001F, 0);
        tbl[28] = mk(1, 0, 0,     1,  5, 0, 32'h7C, 32'hA000_001F, 0);
        tbl[29] = mk(1, 0, 0,     1,  6, 1, 32'h10, 32'hA000_0004, 0);

        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_outs("start", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
            check_outs($sformatf("c%0d", i + 1), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld,
                       tbl[i].e_pc, tbl[i].e_out, tbl[i].e_fim);
        end

        // fill to two entries, then redirect while decode is ready: head must not be popped
        step(0, 0, 0);
        check_outs("fill1", 0, 7, 1, 32'h14, 32'hA000_0005, 0);
        step(0, 0, 0);
        check_outs("fill2", 0, 7, 1, 32'h14, 32'hA000_0005, 0);
        step(1, 1, 32'h40);
        check_outs("rdr_pop", 0, 7, 1, 32'h14, 32'hA000_0005, 0);
        step(1, 0, 0);
        check_outs("flushed", 1, 16, 0, 32'h14, 32'hA000_0005, 0);
        step(1, 0, 0);
        check_outs("refetch", 1, 17, 0, 32'h14, 32'hA000_0005, 0);
        step(1, 0, 0);
        check_outs("new_head", 1, 18, 1, 32'h40, 32'hA000_0010, 0);
        step(1, 0, 0);
        check_outs("next_head", 1, 19, 1, 32'h44, 32'hA000_0011, 0);

        // asynchronous reset between edges with two entries buffered
        step(0, 0, 0);
        check_outs("pre_rst1", 0, 20, 1, 32'h48, 32'hA000_0012, 0);
        step(0, 0, 0);
        check_outs("pre_rst2", 0, 20, 1, 32'h48, 32'hA000_0012, 0);
        #2 reset = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        instr_ready = 1'b1;
        #1;
        check_outs("rel_start", 0, 0, 0, 0, 0, 0);
        step(1, 0, 0);
        check_outs("rel_c1", 1, 0, 0, 0, 0, 0);
        step(1, 0, 0);
        check_outs("rel_c2", 1, 1, 0, 0, 0, 0);
        step(1, 0, 0);
        check_outs("rel_c3", 1, 2, 1, 32'h0, 32'h0640_0193, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
